frame_streamer: RTL

Hardware pixel source that replaces the bench-side stimulus loop. It reads a BMP-layout frame (24-bit BGR, rows padded to 4 bytes) from a byte-addressed frame memory and emits it as a pixel stream into top: data, hsync on row start, vsync on frame start, throttled by the downstream en. It sits between the frame buffer controller and top, and lets the detection pipeline run from on-chip frame storage.

---
 rtl/frame_stream_pkg.sv | 26 ++
 rtl/pix_tag_fifo.sv | 53 +++++
 rtl/frame_streamer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/frame_stream_pkg.sv
// Shared types for the frame streamer: FSM states, tagged pixel entry, row stride helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package frame_stream_pkg;

  localparam int PIX_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic             vsync;
    logic             hsync;
    logic [PIX_W-1:0] pixel;
  } pix_entry_t;

  // BMP rows are 3 bytes per pixel, padded up to a 4-byte boundary.
  function automatic logic [31:0] stride_bytes(input logic [31:0] w);
    return ((w << 1) + w + 32'd3) & ~32'd3;
  endfunction

endpackage

// File: rtl/pix_tag_fifo.sv
// Synchronous FIFO of tagged pixels with occupancy count and same-cycle push/pop.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is dropped when full unless a pop frees a slot in the same cycle.
module pix_tag_fifo
  import frame_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  pix_entry_t             push_dat,
  input  logic                   pop,
  output pix_entry_t             head_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pix_entry_t     store [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign head_dat = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/frame_streamer.sv
// Streams a BMP-layout 24-bit frame from byte-addressed memory as pixels with hsync/vsync tags.
// Latency: start -> mem_rd next cycle -> FIFO write one cycle later -> valid the cycle after.
// Backpressure: en low holds the head; reads stop once buffered plus in-flight pixels fill the FIFO.
module frame_streamer
  import frame_stream_pkg::*;
#(
  parameter int DIM_BITS   = 12,
  parameter int ADDR_BITS  = 22,
  parameter int FIFO_DEPTH = 4,
  parameter int PIXEL_SIZE = PIX_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DIM_BITS-1:0]   width,
  input  logic [DIM_BITS-1:0]   height,
  input  logic [ADDR_BITS-1:0]  base_addr,
  output logic                  mem_rd,
  output logic [ADDR_BITS-1:0]  mem_addr,
  input  logic [PIXEL_SIZE-1:0] mem_rdata,
  input  logic                  en,
  output logic                  valid,
  output logic [PIXEL_SIZE-1:0] data,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;

  state_t                state;
  logic [DIM_BITS-1:0]   width_q;
  logic [DIM_BITS-1:0]   height_q;
  logic [ADDR_BITS-1:0]  stride_q;
  logic [DIM_BITS-1:0]   col;
  logic [DIM_BITS-1:0]   row;
  logic [ADDR_BITS-1:0]  row_base;
  logic [ADDR_BITS-1:0]  pix_addr;

  // Tags ride with mem_rd, then with the returning read data.
  logic                  rd_hs;
  logic                  rd_vs;
  logic                  rd_vld_q;
  logic                  tag_hs_q;
  logic                  tag_vs_q;

  logic                  idle;
  logic                  zero_frame;
  logic                  issue;
  logic                  room;
  logic                  pop;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [OW-1:0]         occupancy;
  logic                  fifo_drained;
  pix_entry_t            push_entry;
  pix_entry_t            head;

  logic [DIM_BITS-1:0]   cur_w;
  logic [DIM_BITS-1:0]   cur_h;
  logic [ADDR_BITS-1:0]  cur_stride;
  logic [DIM_BITS-1:0]   cur_col;
  logic [DIM_BITS-1:0]   cur_row;
  logic [ADDR_BITS-1:0]  cur_addr;
  logic [ADDR_BITS-1:0]  cur_row_base;
  logic [ADDR_BITS-1:0]  next_row_base;
  logic                  col_last;
  logic                  frame_last;
  logic [DIM_BITS-1:0]   nxt_col;
  logic [DIM_BITS-1:0]   nxt_row;
  logic [ADDR_BITS-1:0]  nxt_addr;
  logic [ADDR_BITS-1:0]  nxt_row_base;

  // The first pixel is issued straight out of IDLE, so the walk starts from the start-time inputs.
  assign idle         = (state == IDLE);
  assign cur_w        = idle ? width     : width_q;
  assign cur_h        = idle ? height    : height_q;
  assign cur_stride   = idle ? ADDR_BITS'(stride_bytes(32'(width))) : stride_q;
  assign cur_col      = idle ? '0        : col;
  assign cur_row      = idle ? '0        : row;
  assign cur_addr     = idle ? base_addr : pix_addr;
  assign cur_row_base = idle ? base_addr : row_base;

  assign col_last      = (cur_col == cur_w - DIM_BITS'(1));
  assign frame_last    = col_last && (cur_row == cur_h - DIM_BITS'(1));
  assign next_row_base = cur_row_base + cur_stride;

  always_comb begin
    nxt_col      = cur_col + DIM_BITS'(1);
    nxt_row      = cur_row;
    nxt_addr     = cur_addr + ADDR_BITS'(3);
    nxt_row_base = cur_row_base;
    if (col_last) begin
      nxt_col      = '0;
      nxt_row      = cur_row + DIM_BITS'(1);
      nxt_addr     = next_row_base;
      nxt_row_base = next_row_base;
    end
  end

  assign occupancy    = OW'(fifo_count) + OW'(mem_rd) + OW'(rd_vld_q);
  assign room         = (occupancy < OW'(FIFO_DEPTH));
  assign zero_frame   = idle && start && ((width == '0) || (height == '0));
  assign issue        = (idle && start && !zero_frame) || ((state == RUN) && room);
  assign pop          = valid && en;
  // Counts the final pop as already done so done lands the cycle after the last transfer.
  assign fifo_drained = fifo_empty || ((fifo_count == CW'(1)) && pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      stride_q <= '0;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      pix_addr <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      rd_hs    <= 1'b0;
      rd_vs    <= 1'b0;
      rd_vld_q <= 1'b0;
      tag_hs_q <= 1'b0;
      tag_vs_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      mem_rd   <= 1'b0;
      done     <= 1'b0;
      rd_vld_q <= mem_rd;
      tag_hs_q <= rd_hs;
      tag_vs_q <= rd_vs;

      case (state)
        IDLE: begin
          if (zero_frame) begin
            done <= 1'b1;
          end else if (start) begin
            width_q  <= width;
            height_q <= height;
            stride_q <= cur_stride;
            busy     <= 1'b1;
            state    <= frame_last ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (room && frame_last) state <= DRAIN;
        end
        DRAIN: begin
          if (!mem_rd && !rd_vld_q && fifo_drained) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (issue) begin
        mem_rd   <= 1'b1;
        mem_addr <= cur_addr;
        rd_hs    <= (cur_col == '0);
        rd_vs    <= (cur_col == '0) && (cur_row == '0);
        col      <= nxt_col;
        row      <= nxt_row;
        pix_addr <= nxt_addr;
        row_base <= nxt_row_base;
      end
    end
  end

  assign push_entry = '{vsync: tag_vs_q, hsync: tag_hs_q, pixel: mem_rdata};

  pix_tag_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (rd_vld_q),
    .push_dat (push_entry),
    .pop      (pop),
    .head_dat (head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign valid = !fifo_empty;
  assign data  = valid ? head.pixel : '0;
  assign hsync = valid && head.hsync;
  assign vsync = valid && head.vsync;

endmodule
